ps2_kbd_tx: RTL and testbench

- Keyboard-side PS/2 transmitter: the opposite end of the PS/2 receive path and its scancode-to-ASCII decoder.
- Accepts an ASCII character over a valid/ready handshake and maps it to its PS/2 set-2 make code.
- Serializes the full keystroke (make, F0 break prefix, make) onto ps2_clk/ps2_data, driving the clock itself as a keyboard does.
- Used in simulation and on-board loopback to stimulate the keyboard receiver from the CPU's character stream.

---
 rtl/ps2_kbd_tx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: keyboard-side PS/2 transmitter. Takes an ASCII character and maps it to its
// set-2 make code. Sends the full keystroke (make, F0, make) as three 11-bit frames, generating
// ps2_clk itself. Each frame is followed by GAP_CYCLES of idle line.
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   ascii_in/valid/ready  character input handshake; ready is high only while idle
//   ps2_clk, ps2_data     PS/2 lines, both idle high
//   busy                  high while a keystroke is in progress
//   err_unmapped          one-cycle pulse after accepting a character with no make code
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 1000,
  parameter int GAP_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       err_unmapped
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [7:0]    BREAK     = 8'hF0;

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_e;

  state_e        state_q;
  logic [7:0]    make_q;
  logic [1:0]    byte_q;    // 0: make, 1: break prefix, 2: make again
  logic [3:0]    bit_q;     // 0 start, 1..8 data, 9 parity, 10 stop
  logic [HW-1:0] half_q;
  logic          phase_q;   // 0: clock-high half of the cell, 1: clock-low half
  logic [GW-1:0] gap_q;
  logic          ps2_clk_q;
  logic          ps2_data_q;
  logic          busy_q;
  logic          err_q;

  logic [8:0]    map_d;     // {mapped, make code}
  logic [7:0]    payload_d;
  logic          accept_d;

  // Letters are case-folded first so both cases share one table.
  function automatic logic [8:0] map_ascii(input logic [7:0] c);
    logic [7:0] u;
    u = ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
    case (u)
      8'h41: return {1'b1, 8'h1C};
      8'h42: return {1'b1, 8'h32};
      8'h43: return {1'b1, 8'h21};
      8'h44: return {1'b1, 8'h23};
      8'h45: return {1'b1, 8'h24};
      8'h46: return {1'b1, 8'h2B};
      8'h47: return {1'b1, 8'h34};
      8'h48: return {1'b1, 8'h33};
      8'h49: return {1'b1, 8'h43};
      8'h4A: return {1'b1, 8'h3B};
      8'h4B: return {1'b1, 8'h42};
      8'h4C: return {1'b1, 8'h4B};
      8'h4D: return {1'b1, 8'h3A};
      8'h4E: return {1'b1, 8'h31};
      8'h4F: return {1'b1, 8'h44};
      8'h50: return {1'b1, 8'h4D};
      8'h51: return {1'b1, 8'h15};
      8'h52: return {1'b1, 8'h2D};
      8'h53: return {1'b1, 8'h1B};
      8'h54: return {1'b1, 8'h2C};
      8'h55: return {1'b1, 8'h3C};
      8'h56: return {1'b1, 8'h2A};
      8'h57: return {1'b1, 8'h1D};
      8'h58: return {1'b1, 8'h22};
      8'h59: return {1'b1, 8'h35};
      8'h5A: return {1'b1, 8'h1A};
      8'h30: return {1'b1, 8'h70};
      8'h31: return {1'b1, 8'h69};
      8'h32: return {1'b1, 8'h72};
      8'h33: return {1'b1, 8'h7A};
      8'h34: return {1'b1, 8'h6B};
      8'h35: return {1'b1, 8'h73};
      8'h36: return {1'b1, 8'h74};
      8'h37: return {1'b1, 8'h6C};
      8'h38: return {1'b1, 8'h75};
      8'h39: return {1'b1, 8'h7D};
      default: return 9'h000;
    endcase
  endfunction

  // Line level for a given cell of the frame carrying byte b (odd parity).
  function automatic logic cell_bit(input logic [7:0] b, input logic [3:0] idx);
    logic [7:0] sh;
    sh = b >> (idx - 4'd1);
    case (idx)
      4'd0:    return 1'b0;
      4'd9:    return ~^b;
      4'd10:   return 1'b1;
      default: return sh[0];
    endcase
  endfunction

  assign ascii_ready  = (state_q == IDLE);
  assign accept_d     = ascii_valid & ascii_ready;
  assign map_d        = map_ascii(ascii_in);
  assign payload_d    = (byte_q == 2'd1) ? BREAK : make_q;

  assign ps2_clk      = ps2_clk_q;
  assign ps2_data     = ps2_data_q;
  assign busy         = busy_q;
  assign err_unmapped = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      make_q     <= 8'h00;
      byte_q     <= 2'd0;
      bit_q      <= 4'd0;
      half_q     <= '0;
      phase_q    <= 1'b0;
      gap_q      <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            if (map_d[8]) begin
              // Start bit goes out immediately; clock stays high for the first half-cell.
              make_q     <= map_d[7:0];
              byte_q     <= 2'd0;
              bit_q      <= 4'd0;
              half_q     <= '0;
              phase_q    <= 1'b0;
              ps2_clk_q  <= 1'b1;
              ps2_data_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= FRAME;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FRAME: begin
          if (half_q == HALF_LAST) begin
            half_q <= '0;
            if (!phase_q) begin
              phase_q   <= 1'b1;
              ps2_clk_q <= 1'b0;
            end else begin
              // Data only moves together with the rising clock edge, so it is
              // stable for the whole low half the host samples in.
              phase_q   <= 1'b0;
              ps2_clk_q <= 1'b1;
              if (bit_q == 4'd10) begin
                ps2_data_q <= 1'b1;
                gap_q      <= '0;
                state_q    <= GAP;
              end else begin
                bit_q      <= bit_q + 4'd1;
                ps2_data_q <= cell_bit(payload_d, bit_q + 4'd1);
              end
            end
          end else begin
            half_q <= half_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            if (byte_q == 2'd2) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              byte_q     <= byte_q + 2'd1;
              bit_q      <= 4'd0;
              half_q     <= '0;
              phase_q    <= 1'b0;
              ps2_data_q <= 1'b0;
              state_q    <= FRAME;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
module tb_ps2_kbd_tx;
  localparam int CD      = 4;
  localparam int GAP     = 8;
  localparam int KEY_CYC = 3 * (22 * CD + GAP);   // 288 busy cycles per keystroke

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ascii_in = 8'h00;
  logic       ascii_valid = 1'b0;
  logic       ascii_ready, ps2_clk, ps2_data, busy, err_unmapped;

  ps2_kbd_tx #(.CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .ascii_in(ascii_in), .ascii_valid(ascii_valid),
    .ascii_ready(ascii_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .busy(busy), .err_unmapped(err_unmapped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];      // scoreboard: bytes expected on the line, in order
  int         err_exp = 0;   // outstanding err_unmapped pulses expected
  int         frames_rx = 0;
  int         mon_nbits = 0;
  logic [10:0] mon_fr;
  logic       prev_clk = 1'b1;
  logic       prev_data = 1'b1;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference mapping from the character tables.
  function automatic bit ref_map(input logic [7:0] c, output logic [7:0] code);
    code = 8'h00;
    if (c >= 8'h41 && c <= 8'h5A) begin code = letters[c - 8'h41]; return 1'b1; end
    if (c >= 8'h61 && c <= 8'h7A) begin code = letters[c - 8'h61]; return 1'b1; end
    if (c >= 8'h30 && c <= 8'h39) begin code = digits[c - 8'h30];  return 1'b1; end
    return 1'b0;
  endfunction

  task automatic push_expect(input logic [7:0] c);
    logic [7:0] code;
    if (ref_map(c, code)) begin
      exp_q.push_back(code);
      exp_q.push_back(8'hF0);
      exp_q.push_back(code);
    end else begin
      err_exp++;
    end
  endtask

  // Monitor: acts as the host, sampling ps2_data on ps2_clk falling edges.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      mon_nbits = 0;
      prev_clk  = 1'b1;
      prev_data = 1'b1;
    end else begin
      if (prev_clk && !ps2_clk) begin
        mon_fr[mon_nbits] = ps2_data;
        mon_nbits++;
        if (mon_nbits == 11) begin
          mon_nbits = 0;
          frames_rx++;
          check("start_bit", mon_fr[0], 1'b0);
          check("stop_bit", mon_fr[10], 1'b1);
          check("odd_parity", ^mon_fr[9:1], 1'b1);
          if (exp_q.size() == 0) begin
            fail_now("unexpected_frame");
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", mon_fr[8:1], e);
          end
        end
      end
      if (!prev_clk && !ps2_clk) check("data_stable_clk_low", ps2_data, prev_data);
      if (err_unmapped) begin
        if (err_exp == 0) fail_now("unexpected_err_unmapped");
        else begin
          checks++;
          err_exp--;
        end
      end
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ascii_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ascii_ready) fail_now("timeout_wait_ready");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("timeout_wait_idle");
  endtask

  // One handshake; ascii_in is scrambled right after acceptance to show it was latched.
  task automatic send(input logic [7:0] c);
    logic [7:0] code;
    bit m;
    @(negedge clk);
    wait_ready();
    ascii_in    = c;
    ascii_valid = 1'b1;
    push_expect(c);
    m = ref_map(c, code);
    @(posedge clk);
    #1;
    if (m) check("busy_after_accept", busy, 1'b1);
    else   check("err_after_accept", err_unmapped, 1'b1);
    @(negedge clk);
    ascii_valid = 1'b0;
    ascii_in    = 8'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_fall, first_rise, low, n, base;
    logic [7:0] chars [36];
    logic [7:0] tmp;

    // Reset state, with a character offered during reset that must be ignored.
    #1 reset = 1'b1;
    ascii_valid = 1'b1;
    ascii_in    = 8'h41;
    #1;
    check("rst_ready", ascii_ready, 1'b1);
    check("rst_ps2_clk", ps2_clk, 1'b1);
    check("rst_ps2_data", ps2_data, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_unmapped, 1'b0);
    repeat (3) @(negedge clk);
    ascii_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("valid_in_reset_ignored", busy, 1'b0);

    // 'A': timing of the first cell and of the whole keystroke.
    @(negedge clk);
    ascii_in    = 8'h41;
    ascii_valid = 1'b1;
    push_expect(8'h41);
    @(posedge clk);
    #1;
    check("t1_busy", busy, 1'b1);
    check("t1_ready", ascii_ready, 1'b0);
    check("t1_data_start", ps2_data, 1'b0);
    check("t1_clk_high", ps2_clk, 1'b1);
    @(negedge clk);
    ascii_valid = 1'b0;
    first_fall = 0;
    first_rise = 0;
    low = 0;
    for (int k = 1; k < 400; k++) begin
      if (!ps2_clk && first_fall == 0) first_fall = k;
      if (ps2_clk && first_fall != 0 && first_rise == 0) first_rise = k;
      if (ascii_ready) break;
      low++;
      @(negedge clk);
    end
    check("first_fall_cycle", first_fall, CD + 1);
    check("first_rise_cycle", first_rise, 2 * CD + 1);
    check("ready_low_cycles", low, KEY_CYC);

    // 'z' then '7' with valid held: the second one goes on the first ready cycle.
    @(negedge clk);
    ascii_in    = 8'h7A;
    ascii_valid = 1'b1;
    push_expect(8'h7A);
    push_expect(8'h37);
    @(posedge clk);
    @(negedge clk);
    ascii_in = 8'h37;
    low = 1;
    n = 0;
    @(negedge clk);
    while (!ascii_ready && n < 400) begin
      low++;
      n++;
      @(negedge clk);
    end
    check("b2b_ready_low_cycles", low, KEY_CYC);
    @(posedge clk);
    #1;
    check("b2b_second_accept", busy, 1'b1);
    @(negedge clk);
    ascii_valid = 1'b0;
    wait_idle();

    // Unmapped '!'.
    @(negedge clk);
    ascii_in    = 8'h21;
    ascii_valid = 1'b1;
    push_expect(8'h21);
    @(posedge clk);
    #1;
    check("unm_err_t1", err_unmapped, 1'b1);
    check("unm_busy", busy, 1'b0);
    check("unm_ready", ascii_ready, 1'b1);
    check("unm_lines", {ps2_clk, ps2_data}, 2'b11);
    @(negedge clk);
    ascii_valid = 1'b0;
    @(posedge clk);
    #1;
    check("unm_err_t2", err_unmapped, 1'b0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (!ps2_clk || !ps2_data || busy || !ascii_ready) n++;
    end
    check("unm_line_activity", n, 0);

    // Reset in the middle of the F0 frame, during its bit 5 cell.
    base = frames_rx;
    send(8'h41);
    n = 0;
    while (!(frames_rx == base + 1 && mon_nbits == 6) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now("timeout_reset_point");
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ps2_clk", ps2_clk, 1'b1);
    check("mid_rst_ps2_data", ps2_data, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (!ps2_clk || busy) n++;
    end
    check("no_resume_after_reset", n, 0);
    base = frames_rx;
    send(8'h42);
    wait_idle();
    check("after_reset_frames", frames_rx - base, 3);

    // All 36 mapped characters, random case and order, then random bytes.
    for (int i = 0; i < 26; i++)
      chars[i] = 8'(8'h41 + i + ($urandom_range(0, 1) * 32));
    for (int i = 0; i < 10; i++) chars[26 + i] = 8'(8'h30 + i);
    for (int i = 35; i > 0; i--) begin
      int j;
      j = $urandom_range(0, i);
      tmp = chars[i];
      chars[i] = chars[j];
      chars[j] = tmp;
    end
    for (int i = 0; i < 36; i++) send(chars[i]);
    for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)));
    wait_idle();
    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("err_pulses_seen", err_exp, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
